// File: rtl/cdc_stable_capture.sv
// cdc_stable_capture
//
// Qualifies a multi-bit bus arriving from a per-bit async_ff synchronizer.
// The bits of such a bus can resolve on different cycles, so a new value is
// only accepted once it has held constant for NSTB consecutive CP cycles.
// The accepted value is then offered downstream on a valid/ready handshake.
//
// Parameters:
//   DW   - bus width
//   NSTB - consecutive equal samples required before capture (1..255)
//   CW   - glitch counter width (only with the optional feature)
//
// Ports:
//   CP         in   clock, rising edge
//   CLR        in   asynchronous active-high reset
//   D          in   bus from the synchronizer output
//   Q          out  qualified data
//   VLD        out  Q holds a new qualified value
//   RDY        in   downstream accepts Q
//   BUSY       out  a change is settling or waiting to be accepted
//   GLITCH_CNT out  saturating count of aborted settle attempts
//
// Optional feature: define CDC_STABLE_CAPTURE_GLITCH_CNT_EN to add the
// GLITCH_CNT port and its counter. Without it the port does not exist.

module cdc_stable_capture #(
    parameter int DW   = 8,
    parameter int NSTB = 3
`ifdef CDC_STABLE_CAPTURE_GLITCH_CNT_EN
    ,
    parameter int CW   = 8
`endif
) (
    input  logic          CP,
    input  logic          CLR,
    input  logic [DW-1:0] D,
    output logic [DW-1:0] Q,
    output logic          VLD,
    input  logic          RDY,
    output logic          BUSY
`ifdef CDC_STABLE_CAPTURE_GLITCH_CNT_EN
    ,
    output logic [CW-1:0] GLITCH_CNT
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    // Counter value at which the next matching sample completes the window.
    localparam logic [7:0] CNT_LAST = 8'(NSTB - 1);

    state_t        state;
    state_t        state_nxt;
    logic [DW-1:0] d_r;
    logic [DW-1:0] ref_val;
    logic [DW-1:0] cand;
    logic [DW-1:0] q_r;
    logic [7:0]    cnt;

    logic          do_capture;
    logic          do_start;
    logic          do_incr;
    logic          do_clear;

    // State register.
    always_ff @(posedge CP or posedge CLR) begin
        if (CLR) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and datapath strobes. SETTLE checks are ordered so
    // that completing the window wins over simply counting, and returning to
    // the old value wins over restarting on a third value.
    always_comb begin
        state_nxt  = state;
        do_capture = 1'b0;
        do_start   = 1'b0;
        do_incr    = 1'b0;
        do_clear   = 1'b0;
        case (state)
            IDLE: begin
                if (d_r != ref_val) begin
                    if (NSTB == 1) begin
                        do_capture = 1'b1;
                        state_nxt  = HOLD;
                    end else begin
                        do_start  = 1'b1;
                        state_nxt = SETTLE;
                    end
                end
            end
            SETTLE: begin
                if ((d_r == cand) && (cnt == CNT_LAST)) begin
                    do_capture = 1'b1;
                    state_nxt  = HOLD;
                end else if (d_r == cand) begin
                    do_incr = 1'b1;
                end else if (d_r == ref_val) begin
                    do_clear  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    do_start = 1'b1;
                end
            end
            HOLD: begin
                if (RDY) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath registers. On a capture from SETTLE the candidate equals the
    // current sample, so both capture paths load from d_r.
    always_ff @(posedge CP or posedge CLR) begin
        if (CLR) begin
            d_r     <= '0;
            ref_val <= '0;
            cand    <= '0;
            q_r     <= '0;
            cnt     <= 8'd0;
        end else begin
            d_r <= D;
            if (do_capture) begin
                q_r     <= d_r;
                ref_val <= d_r;
            end
            if (do_start) begin
                cand <= d_r;
                cnt  <= 8'd1;
            end else if (do_incr) begin
                cnt <= cnt + 8'd1;
            end else if (do_clear) begin
                cnt <= 8'd0;
            end
        end
    end

    // Output decode straight from registers; nothing depends on RDY here.
    always_comb begin
        Q    = q_r;
        VLD  = (state == HOLD);
        BUSY = (state != IDLE);
    end

`ifdef CDC_STABLE_CAPTURE_GLITCH_CNT_EN
    // Any SETTLE sample that differs from the candidate is an aborted
    // attempt: either a return to the old value or a jump to a third one.
    logic          glitch;
    logic [CW-1:0] glitch_cnt;

    assign glitch = (state == SETTLE) && (d_r != cand);

    // Saturating glitch counter, cleared only by CLR.
    always_ff @(posedge CP or posedge CLR) begin
        if (CLR) begin
            glitch_cnt <= '0;
        end else if (glitch && (glitch_cnt != {CW{1'b1}})) begin
            glitch_cnt <= glitch_cnt + 1'b1;
        end
    end

    assign GLITCH_CNT = glitch_cnt;
`endif

endmodule

// File: tb/tb_cdc_stable_capture.sv
// Testbench for cdc_stable_capture (DW=8, NSTB=3, CW=2 when the glitch
// counter is enabled). Uses a run-length reference model: a value other than
// the last delivered one is accepted once it has been seen NSTB samples in a
// row while no delivered value is waiting.

module tb_cdc_stable_capture;

    localparam int DW    = 8;
    localparam int NSTB  = 3;
    localparam int TB_CW = 2;

    logic          CP = 1'b0;
    logic          CLR;
    logic [DW-1:0] D;
    logic [DW-1:0] Q;
    logic          VLD;
    logic          RDY;
    logic          BUSY;
`ifdef CDC_STABLE_CAPTURE_GLITCH_CNT_EN
    logic [TB_CW-1:0] GLITCH_CNT;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    logic [DW-1:0] m_dr;
    logic [DW-1:0] m_ref;
    logic [DW-1:0] m_run_val;
    int            m_run_len;
    logic          m_hold;
    logic [DW-1:0] m_q;
    int            m_glitch;

    typedef struct {
        logic [DW-1:0] d;
        logic          rdy;
        logic          exp_vld;
        logic          exp_busy;
        logic [DW-1:0] exp_q;
    } vec_t;

    vec_t          table_v[10];
    logic [DW-1:0] pool[5];

    cdc_stable_capture #(
        .DW(DW),
        .NSTB(NSTB)
`ifdef CDC_STABLE_CAPTURE_GLITCH_CNT_EN
        ,
        .CW(TB_CW)
`endif
    ) dut (
        .CP(CP),
        .CLR(CLR),
        .D(D),
        .Q(Q),
        .VLD(VLD),
        .RDY(RDY),
        .BUSY(BUSY)
`ifdef CDC_STABLE_CAPTURE_GLITCH_CNT_EN
        ,
        .GLITCH_CNT(GLITCH_CNT)
`endif
    );

    always #5 CP = ~CP;

    task automatic checkVal(input string name, input logic [31:0] actual,
                            input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_dr      = '0;
        m_ref     = '0;
        m_run_val = '0;
        m_run_len = 0;
        m_hold    = 1'b0;
        m_q       = '0;
        m_glitch  = 0;
    endtask

    task automatic glitchBump();
        if (m_glitch < (1 << TB_CW) - 1) m_glitch++;
    endtask

    // One clock edge of the model, using the values present before the edge.
    task automatic modelEdge(input logic [DW-1:0] d_in, input logic rdy_in,
                             input logic clr_in);
        if (clr_in) begin
            modelReset();
            return;
        end
        if (m_hold) begin
            if (rdy_in) m_hold = 1'b0;
        end else if (m_dr == m_ref) begin
            if (m_run_len > 0) glitchBump();
            m_run_len = 0;
        end else if ((m_run_len > 0) && (m_dr == m_run_val)) begin
            m_run_len++;
        end else begin
            if (m_run_len > 0) glitchBump();
            m_run_val = m_dr;
            m_run_len = 1;
        end
        if (!m_hold && (m_run_len >= NSTB)) begin
            m_q       = m_run_val;
            m_ref     = m_run_val;
            m_hold    = 1'b1;
            m_run_len = 0;
        end
        m_dr = d_in;
    endtask

    // Drive inputs, take one edge, advance the model, settle away from edge.
    task automatic applyStimulus(input logic [DW-1:0] d, input logic rdy);
        D   = d;
        RDY = rdy;
        @(posedge CP);
        modelEdge(d, rdy, CLR);
        #1;
    endtask

    task automatic checkOutput(input string name);
        checkVal({name, "_vld"}, 32'(VLD), 32'(m_hold));
        checkVal({name, "_busy"}, 32'(BUSY), 32'(m_hold || (m_run_len > 0)));
        checkVal({name, "_q"}, 32'(Q), 32'(m_q));
`ifdef CDC_STABLE_CAPTURE_GLITCH_CNT_EN
        checkVal({name, "_gcnt"}, 32'(GLITCH_CNT), 32'(m_glitch));
`endif
    endtask

    // Asserts CLR between edges, checks the immediate clear, holds it over
    // one edge and releases it just after that edge.
    task automatic doReset(input logic [DW-1:0] d);
        D = d;
        #1;
        CLR = 1'b1;
        #1;
        modelReset();
        checkVal("reset_async_vld", 32'(VLD), 32'd0);
        checkVal("reset_async_busy", 32'(BUSY), 32'd0);
        checkVal("reset_async_q", 32'(Q), 32'd0);
        applyStimulus(d, 1'b1);
        checkOutput("reset_held");
        CLR = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] cur;

        modelReset();
        CLR = 1'b1;
        D   = 8'hA5;
        RDY = 1'b1;
        pool[0] = 8'h00;
        pool[1] = 8'h0F;
        pool[2] = 8'hF0;
        pool[3] = 8'hFF;
        pool[4] = 8'h55;

        // Clean change, accept, then a one-cycle glitch back to the old value.
        table_v[0] = '{8'h3C, 1'b1, 1'b0, 1'b0, 8'h00};
        table_v[1] = '{8'h3C, 1'b1, 1'b0, 1'b1, 8'h00};
        table_v[2] = '{8'h3C, 1'b1, 1'b0, 1'b1, 8'h00};
        table_v[3] = '{8'h3C, 1'b1, 1'b1, 1'b1, 8'h3C};
        table_v[4] = '{8'h3C, 1'b1, 1'b0, 1'b0, 8'h3C};
        table_v[5] = '{8'h3C, 1'b1, 1'b0, 1'b0, 8'h3C};
        table_v[6] = '{8'h3D, 1'b1, 1'b0, 1'b0, 8'h3C};
        table_v[7] = '{8'h3C, 1'b1, 1'b0, 1'b1, 8'h3C};
        table_v[8] = '{8'h3C, 1'b1, 1'b0, 1'b0, 8'h3C};
        table_v[9] = '{8'h3C, 1'b1, 1'b0, 1'b0, 8'h3C};

        @(posedge CP);
        #1;

        // Reset with A5 on the bus, then a single VLD pulse 4 edges later.
        doReset(8'hA5);
        for (int e = 1; e <= 7; e++) begin
            applyStimulus(8'hA5, 1'b1);
            checkVal($sformatf("rst_release_e%0d_vld", e), 32'(VLD),
                     32'(e == 4));
            if (e == 4) checkVal("rst_release_q", 32'(Q), 32'hA5);
            checkOutput("rst_release");
        end

        // Table-driven clean change and glitch-back.
        doReset(8'h00);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(table_v[i].d, table_v[i].rdy);
            checkVal($sformatf("table%0d_vld", i), 32'(VLD),
                     32'(table_v[i].exp_vld));
            checkVal($sformatf("table%0d_busy", i), 32'(BUSY),
                     32'(table_v[i].exp_busy));
            checkVal($sformatf("table%0d_q", i), 32'(Q),
                     32'(table_v[i].exp_q));
            checkOutput("table");
        end
`ifdef CDC_STABLE_CAPTURE_GLITCH_CNT_EN
        checkVal("glitch_back_gcnt", 32'(GLITCH_CNT), 32'd1);
`endif

        // Skew walk 00 -> 0F -> FF: one capture of FF on the fifth edge.
        doReset(8'h00);
        for (int e = 1; e <= 7; e++) begin
            applyStimulus((e == 1) ? 8'h0F : 8'hFF, 1'b1);
            checkVal($sformatf("skew_e%0d_vld", e), 32'(VLD), 32'(e == 5));
            if (e == 5) checkVal("skew_q", 32'(Q), 32'hFF);
            checkOutput("skew");
        end
`ifdef CDC_STABLE_CAPTURE_GLITCH_CNT_EN
        checkVal("skew_gcnt", 32'(GLITCH_CNT), 32'd1);
`endif

        // Backpressure: 55 held while D moves to AA, then AA follows.
        doReset(8'h00);
        for (int e = 1; e <= 4; e++) begin
            applyStimulus(8'h55, 1'b0);
            checkOutput("bp_capture");
        end
        checkVal("bp_capture_vld", 32'(VLD), 32'd1);
        checkVal("bp_capture_q", 32'(Q), 32'h55);
        for (int e = 1; e <= 10; e++) begin
            applyStimulus(8'hAA, 1'b0);
            checkVal("bp_hold_vld", 32'(VLD), 32'd1);
            checkVal("bp_hold_q", 32'(Q), 32'h55);
            checkOutput("bp_hold");
        end
        applyStimulus(8'hAA, 1'b1);
        checkVal("bp_accept_vld", 32'(VLD), 32'd0);
        checkOutput("bp_accept");
        for (int e = 1; e <= 3; e++) begin
            applyStimulus(8'hAA, 1'b0);
            checkVal($sformatf("bp_next_e%0d_vld", e), 32'(VLD), 32'(e == 3));
            checkOutput("bp_next");
        end
        checkVal("bp_next_q", 32'(Q), 32'hAA);

        // CLR mid-HOLD: VLD is high here and must drop without an edge.
        doReset(8'h00);

`ifdef CDC_STABLE_CAPTURE_GLITCH_CNT_EN
        // Five glitch-backs saturate a 2-bit counter at 3.
        for (int g = 0; g < 5; g++) begin
            applyStimulus(8'h01, 1'b1);
            applyStimulus(8'h00, 1'b1);
            applyStimulus(8'h00, 1'b1);
            checkOutput("sat");
        end
        checkVal("sat_gcnt", 32'(GLITCH_CNT), 32'd3);
`endif

        // Randomized traffic against the model, with occasional resets.
        cur = 8'h00;
        doReset(cur);
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) doReset(cur);
            if ($urandom_range(0, 9) < 3) cur = pool[$urandom_range(0, 4)];
            applyStimulus(cur, 1'($urandom_range(0, 1)));
            checkOutput("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cdc_stable_capture.md
# cdc_stable_capture

Qualifies a multi-bit bus that has just been brought into the CP domain by the per-bit `async_ff` synchronizer stage. Bits of such a bus can resolve on different cycles, so the raw value is not trusted. A new value is accepted only after it has held constant for NSTB consecutive CP cycles. The accepted value is then presented downstream on a valid/ready handshake. The block sits directly downstream of `async_ff`: its D is that stage's Q.

## Interface
- DW, 8: bus width.
- NSTB, 3: consecutive equal samples required before capture; legal range 1..255.
- CW, 8: width of the glitch counter (present only when the macro is defined).

- CP  in  1  clock, rising edge.
- CLR  in  1  asynchronous active-high reset.
- D  in  DW  bus from the synchronizer output.
- Q  out  DW  qualified data.
- VLD  out  1  Q holds a new qualified value.
- RDY  in  1  downstream accepts Q.
- BUSY  out  1  a change is settling or waiting to be accepted.
- GLITCH_CNT  out  CW  count of aborted settle attempts (present only when the macro is defined).

## Operation
- **Registers**
  - D_r: input sample, loaded every edge.
  - ref: last delivered value.
  - cand: candidate value.
  - cnt: 8-bit settle counter.
  - state: IDLE, SETTLE or HOLD.
- **Reset (CLR=1)**
  - D_r, ref, cand, Q = 0.
  - cnt = 0, state = IDLE.
  - VLD = 0, BUSY = 0, GLITCH_CNT = 0.
  - All outputs are cleared immediately, without waiting for an edge.
- **IDLE**
  - If D_r == ref: stay in IDLE.
  - Else, when NSTB == 1: Q ← D_r, ref ← D_r, VLD ← 1, go to HOLD.
  - Else: cand ← D_r, cnt ← 1, go to SETTLE.
- **SETTLE**, evaluated in this priority order:
  - D_r == cand and cnt == NSTB-1: Q ← cand, ref ← cand, VLD ← 1, go to HOLD.
  - D_r == cand: cnt ← cnt+1.
  - D_r == ref: the bus returned to its old value. This is a glitch; go to IDLE and clear cnt.
  - Otherwise: the bus moved to a third value. This is a glitch; cand ← D_r, cnt ← 1, stay in SETTLE.
- **HOLD**
  - VLD = 1 and Q is frozen.
  - On an edge with RDY = 1: VLD ← 0, go to IDLE.
  - Input changes during HOLD are not tracked. Because ref was updated at capture, IDLE re-detects any difference on the cycle after acceptance. A change is only lost if the bus returns to ref before acceptance, which is by design.
- **BUSY** = (state != IDLE), decoded from registers.
- **RDY**
  - RDY is ignored outside HOLD.
  - RDY may be held high continuously.
  - No output depends combinationally on RDY.

## Timing
- Define edge k as the edge where D_r first loads a new value V, with V != ref.
- SETTLE is entered at edge k+1 (when NSTB > 1).
- Capture occurs at edge k+NSTB: Q = V and VLD = 1 after that edge.
- End to end, VLD rises NSTB+1 edges after V is first presented on D.
- With RDY held high, VLD is a one-cycle pulse.
- IDLE is re-entered on the accept edge. Back-to-back captures are therefore spaced by at least NSTB+1 cycles.
- Any D change inside the settle window resets the window. The total latency is measured from the last change.
- CLR asserted mid-SETTLE or mid-HOLD:
  - Any pending value is discarded and VLD drops at once.
  - After release, a nonzero D is treated as a new change against ref = 0.

## Configuration
- `CDC_STABLE_CAPTURE_GLITCH_CNT_EN`
- **Defined:** GLITCH_CNT is present.
  - It increments by 1 on each SETTLE→IDLE glitch and each third-value glitch.
  - It saturates at 2^CW−1 and does not wrap.
  - It is cleared only by CLR.
- **Undefined:** the port and its counter are removed entirely. All other behaviour is identical.

## Test plan
- **Reset**: hold CLR=1 while D=8'hA5 → Q=0, VLD=0, BUSY=0. After release with D=8'hA5 held and RDY=1 → VLD pulses for exactly 1 cycle with Q=8'hA5, 4 edges after release (NSTB=3).
- **Clean change**: D 8'h00→8'h3C, RDY=1 → D_r loads at edge k, BUSY=1 after edge k+1, one-cycle VLD pulse after edge k+3 with Q=8'h3C.
- **Glitch-back**: D 8'h00→8'h01 for 1 cycle, then back to 8'h00 → no VLD, BUSY returns to 0, GLITCH_CNT=1 (macro on).
- **Skew walk**: D 8'h00→8'h0F→8'hFF, one cycle apart → single VLD with Q=8'hFF, 3 edges after D_r=8'hFF; GLITCH_CNT=1.
- **Backpressure**: capture 8'h55 with RDY=0 for 10 cycles while D moves to 8'hAA → VLD stays high and Q stays 8'h55. Raise RDY → accept. Then VLD with Q=8'hAA follows 3 edges later.
- **Reset mid-HOLD and saturation**: assert CLR while VLD=1 → VLD drops with no edge needed. With CW=2 and 5 glitches → GLITCH_CNT=3.
